// File: rtl/en_strobe_gen_pkg.sv
// Shared types and defaults for the en_strobe_gen clock-enable strobe generator.
// Build option EN_STROBE_GEN_IMMEDIATE_EN (see en_strobe_prescaler) moves the first strobe to phase 0.
package en_strobe_gen_pkg;

  localparam int DIV_WIDTH_DEF   = 8;
  localparam int BURST_WIDTH_DEF = 4;

  localparam logic [1:0] IDLE_ENC = 2'b00;
  localparam logic [1:0] RUN_ENC  = 2'b01;
  localparam logic [1:0] DONE_ENC = 2'b10;

  typedef enum logic [1:0] {
    IDLE = IDLE_ENC,
    RUN  = RUN_ENC,
    DONE = DONE_ENC
  } state_e;

endpackage

// File: rtl/en_strobe_prescaler.sv
// Loadable down-counter producing a registered terminal-count tick every (div_i+1) cycles.
// With EN_STROBE_GEN_IMMEDIATE_EN defined the tick also fires in the cycle right after load.
module en_strobe_prescaler #(
  parameter int DivWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic                run_i,
  input  logic [DivWidth-1:0] div_i,
  output logic                tick_o
);

  localparam logic [DivWidth-1:0] DivOne = DivWidth'(1);

  logic [DivWidth-1:0] cnt_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
      tick_o  <= 1'b0;
    end else if (load_i) begin
`ifdef EN_STROBE_GEN_IMMEDIATE_EN
      // Behave as if a terminal count was just reached: strobe now, full period next.
      tick_o  <= 1'b1;
      cnt_reg <= div_i;
`else
      // Preload so the first tick lands div_i+1 cycles after the load edge.
      if (div_i == '0) begin
        tick_o  <= 1'b1;
        cnt_reg <= '0;
      end else begin
        tick_o  <= 1'b0;
        cnt_reg <= div_i - DivOne;
      end
`endif
    end else if (run_i) begin
      if (cnt_reg == '0) begin
        tick_o  <= 1'b1;
        cnt_reg <= div_i;
      end else begin
        tick_o  <= 1'b0;
        cnt_reg <= cnt_reg - DivOne;
      end
    end else begin
      tick_o <= 1'b0;
    end
  end

endmodule

// File: rtl/en_strobe_gen.sv
// Programmable clock-enable strobe generator: start/busy/done handshake, burst or continuous run.
// Optional build macro EN_STROBE_GEN_IMMEDIATE_EN places the first strobe in cycle 1 after accept.
module en_strobe_gen
  import en_strobe_gen_pkg::*;
#(
  parameter int DivWidth   = DIV_WIDTH_DEF,
  parameter int BurstWidth = BURST_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [DivWidth-1:0]   div_i,
  input  logic [BurstWidth-1:0] burst_i,
  output logic                  en_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [BurstWidth-1:0] BurstOne = BurstWidth'(1);

  state_e                state_reg;
  logic [DivWidth-1:0]   div_reg;
  logic [BurstWidth-1:0] burst_reg;
  logic [BurstWidth-1:0] strobe_cnt_reg;
  logic                  tick;
  logic                  accept;
  logic                  last_strobe;
  logic                  finish;
  logic                  pre_run;
  logic [DivWidth-1:0]   div_sel;

  assign accept      = (state_reg == IDLE) && start_i && !stop_i;
  assign last_strobe = en_o && (burst_reg != '0) && ((strobe_cnt_reg + BurstOne) == burst_reg);
  assign finish      = (state_reg == RUN) && (stop_i || last_strobe);
  // Holding the prescaler on the finishing edge suppresses any strobe due in DONE.
  assign pre_run     = (state_reg == RUN) && !finish;
  assign div_sel     = accept ? div_i : div_reg;

  en_strobe_prescaler #(
    .DivWidth(DivWidth)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (accept),
    .run_i  (pre_run),
    .div_i  (div_sel),
    .tick_o (tick)
  );

  assign en_o = tick;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      div_reg        <= '0;
      burst_reg      <= '0;
      strobe_cnt_reg <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_o <= 1'b0;
          if (accept) begin
            state_reg      <= RUN;
            div_reg        <= div_i;
            burst_reg      <= burst_i;
            strobe_cnt_reg <= '0;
            busy_o         <= 1'b1;
          end
        end
        RUN: begin
          if (en_o && (burst_reg != '0)) begin
            strobe_cnt_reg <= strobe_cnt_reg + BurstOne;
          end
          if (finish) begin
            state_reg <= DONE;
            done_o    <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_o    <= 1'b0;
          done_o    <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_o    <= 1'b0;
          done_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_en_strobe_gen.sv
// Scoreboard bench for en_strobe_gen: per-cycle expected {en,busy,done} queued at drive time.
// Expectations follow EN_STROBE_GEN_IMMEDIATE_EN when the bench is built with that macro.
module tb_en_strobe_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] div = '0;
  logic [3:0] burst = '0;
  logic       en, busy, done;

  typedef struct {
    logic [2:0] exp;
    int         cyc;
  } exp_t;

  exp_t  sb[$];
  int    vectors = 0;
  int    miscompares = 0;
  string cur = "init";
  bit    imm = 1'b0;

  always #5 clk = ~clk;

  en_strobe_gen dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .stop_i  (stop),
    .div_i   (div),
    .burst_i (burst),
    .en_o    (en),
    .busy_o  (busy),
    .done_o  (done)
  );

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if ({en, busy, done} !== e.exp) begin
        miscompares++;
        $display("FAIL %s cycle %0d: en/busy/done=%b, expected %b", cur, e.cyc, {en, busy, done}, e.exp);
      end
    end
  end

  // Reference behaviour: start accepted in cycle 0, stop driven in cycle s (-1 = never).
  function automatic logic [2:0] model(int c, int dv, int bu, int s);
    int f, p, d;
    if (s == 0 || c <= 0) return 3'b000;
    f = imm ? 1 : dv + 1;
    p = dv + 1;
    d = (bu > 0) ? f + (bu - 1) * p + 1 : (1 << 30);
    if (s >= 1 && s <= d - 1) d = s + 1;
    if (c < d) return {(c >= f && ((c - f) % p) == 0), 1'b1, 1'b0};
    if (c == d) return 3'b011;
    return 3'b000;
  endfunction

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL %s drain: %0d vectors pending, expected 0", cur, sb.size());
      sb.delete();
    end
  endtask

  // rs: cycle of an extra start pulse (div=1, burst=7) that must be ignored; rst_at: 3-cycle reset.
  task automatic run_case(string name, int dv, int bu, int s, int rs, int n, int rst_at = -1);
    exp_t e;
    cur = name;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      start = (c == 0) || (c == rs);
      stop  = (c == s);
      rst   = (rst_at >= 0) && (c >= rst_at) && (c < rst_at + 3);
      if (c == 0) begin
        div   = 8'(dv);
        burst = 4'(bu);
      end else if (c == rs) begin
        div   = 8'd1;
        burst = 4'd7;
      end else begin
        div   = 8'(~dv);
        burst = 4'(~bu);
      end
      e.cyc = c;
      e.exp = (rst_at >= 0 && c > rst_at) ? 3'b000 : model(c, dv, bu, s);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    rst   = 1'b0;
    drain();
    $display("case %s div=%0d burst=%0d stop=%0d restart=%0d cycles=%0d", name, dv, bu, s, rs, n);
  endtask

  task automatic test_reset();
    cur = "reset_state";
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({en, busy, done} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_state: en/busy/done=%b, expected 000", {en, busy, done});
    end
    run_case("reset_midrun", 3, 0, -1, -1, 14, 6);
  endtask

  task automatic test_burst();
    run_case("div3_burst2", 3, 2, -1, -1, 12);
    run_case("div1_burst1", 1, 1, -1, -1, 6);
  endtask

  task automatic test_stop();
    run_case("div0_stop5", 0, 0, 5, -1, 10);
    run_case("stop_at_last", 1, 2, 4, -1, 8);
    run_case("start_stop_idle", 2, 1, 0, -1, 6);
  endtask

  task automatic test_restart_ignored();
    run_case("restart_in_run", 3, 3, -1, 6, 18);
    run_case("restart_in_done", 1, 1, -1, imm ? 2 : 3, 8);
  endtask

  task automatic test_max_div();
    run_case("div255_burst1", 255, 1, -1, -1, 260);
  endtask

  task automatic test_immediate();
    run_case("div3_burst3", 3, 3, -1, -1, 16);
  endtask

  task automatic test_back_to_back();
    run_case("b2b_div0_burst2", 0, 2, -1, -1, 5);
    run_case("b2b_div1_burst15", 1, 15, -1, -1, 35);
  endtask

  initial begin
`ifdef EN_STROBE_GEN_IMMEDIATE_EN
    imm = 1'b1;
`else
    imm = 1'b0;
`endif
    test_reset();
    test_burst();
    test_stop();
    test_restart_ignored();
    test_max_div();
    test_immediate();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
